// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA arbiter slice: datapath widths,
// arbiter FSM states and the logic-mode op_sel encodings.
package ula_pkg;

    localparam int ULA_W = 6;
    localparam int OP_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ula_arb_state_t;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b011;

    // Modulo-n increment used for the rotating priority pointer.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Request/response bundle between the requesting control blocks (master)
// and the shared-ULA arbiter (slave).
interface ula_arbiter_if
    import ula_pkg::*;
#(
    parameter int NREQ = 2
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ULA_W-1:0] req_a;
    logic [NREQ*ULA_W-1:0] req_b;
    logic [NREQ-1:0]       req_modo;
    logic [NREQ*OP_W-1:0]  req_op_sel;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [ULA_W-1:0]      rsp_o;
    logic                  rsp_carry;
    logic                  rsp_zero;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_modo, req_op_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_o, rsp_carry, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_modo, req_op_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_o, rsp_carry, rsp_zero, busy
    );

endinterface

// File: rtl/ula.sv
// Combinational 6-bit ULA: modo=1 selects bitwise logic ops, modo=0 selects
// arithmetic/shift ops; reset forces a zero result.
module ula
    import ula_pkg::*;
(
    input  logic             reset,
    input  logic [ULA_W-1:0] a,
    input  logic [ULA_W-1:0] b,
    input  logic             modo,
    input  logic [OP_W-1:0]  op_sel,
    output logic [ULA_W-1:0] o,
    output logic             carry_out,
    output logic             zero
);
    // Bit ULA_W carries the arithmetic carry/borrow or the shifted-out bit.
    logic [ULA_W:0] res;

    always_comb begin
        res = '0;
        if (reset) begin
            res = '0;
        end else if (modo) begin
            case (op_sel)
                OP_AND:  res = {1'b0, a & b};
                OP_OR:   res = {1'b0, a | b};
                OP_XOR:  res = {1'b0, a ^ b};
                OP_NOTA: res = {1'b0, ~a};
                3'b100:  res = {1'b0, ~(a & b)};
                3'b101:  res = {1'b0, ~(a | b)};
                3'b110:  res = {1'b0, ~(a ^ b)};
                default: res = {1'b0, ~b};
            endcase
        end else begin
            case (op_sel)
                3'b000:  res = {1'b0, a} + {1'b0, b};
                3'b001:  res = {1'b0, a} - {1'b0, b};
                3'b010:  res = {1'b0, a} + (ULA_W+1)'(1);
                3'b011:  res = {1'b0, a} - (ULA_W+1)'(1);
                3'b100:  res = {a, 1'b0};
                3'b101:  res = {a[0], 1'b0, a[ULA_W-1:1]};
                3'b110:  res = {1'b0, a};
                default: res = {1'b0, b};
            endcase
        end
    end

    assign o         = res[ULA_W-1:0];
    assign carry_out = res[ULA_W];
    assign zero      = (res[ULA_W-1:0] == '0);

endmodule

// File: rtl/ula_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// otherwise the lowest set request (wrap-around).
module ula_rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] sel;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign hi_mask[gi] = req[gi] && (IDW'(gi) >= ptr);
        end
    endgenerate

    assign any = |req;

    always_comb begin
        sel = (|hi_mask) ? hi_mask : req;
        gnt_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (sel[i]) gnt_id = IDW'(i);
        end
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any && (gnt_id == IDW'(i));
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ULA among NREQ requesters: round-robin grant in IDLE, operands
// registered into the ULA in EXEC, result held on the response port in RESP.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic         clk,
    input  logic         reset,
    ula_arbiter_if.slave bus
);
    ula_arb_state_t   state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   id_q;
    logic [ULA_W-1:0] op_a_q;
    logic [ULA_W-1:0] op_b_q;
    logic             op_modo_q;
    logic [OP_W-1:0]  op_sel_q;
    logic             rsp_valid_q;
    logic [ULA_W-1:0] rsp_o_q;
    logic             rsp_carry_q;
    logic             rsp_zero_q;
    logic             busy_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             any_req;
    logic [ULA_W-1:0] ula_o;
    logic             ula_carry;
    logic             ula_zero;

    logic [ULA_W-1:0] a_arr   [NREQ];
    logic [ULA_W-1:0] b_arr   [NREQ];
    logic [OP_W-1:0]  op_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = bus.req_a[gi*ULA_W +: ULA_W];
            assign b_arr[gi]  = bus.req_b[gi*ULA_W +: ULA_W];
            assign op_arr[gi] = bus.req_op_sel[gi*OP_W +: OP_W];
        end
    endgenerate

    ula_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any_req)
    );

    ula u_ula (
        .reset     (reset),
        .a         (op_a_q),
        .b         (op_b_q),
        .modo      (op_modo_q),
        .op_sel    (op_sel_q),
        .o         (ula_o),
        .carry_out (ula_carry),
        .zero      (ula_zero)
    );

    assign ptr_d = IDW'(wrap_inc(int'(gnt_id), NREQ));

    // Grant is only offered in IDLE, so at most one operation is ever in flight.
    assign bus.req_ready = (state_q == IDLE && !reset) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_modo_q   <= 1'b0;
            op_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        op_a_q    <= a_arr[gnt_id];
                        op_b_q    <= b_arr[gnt_id];
                        op_modo_q <= bus.req_modo[gnt_id];
                        op_sel_q  <= op_arr[gnt_id];
                        id_q      <= gnt_id;
                        ptr_q     <= ptr_d;
                        busy_q    <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_o_q     <= ula_o;
                    rsp_carry_q <= ula_carry;
                    rsp_zero_q  <= ula_zero;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_o     = rsp_o_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares every accepted response.
module tb_ula_arbiter;
    import ula_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ula_arbiter_if #(.NREQ(NREQ)) bus ();

    ula_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [5:0]     o;
        logic           c;
        logic           z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input int o, input int c, input int z);
        exp_t e;
        e.id = id[IDW-1:0];
        e.o  = o[5:0];
        e.c  = c[0];
        e.z  = z[0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b,
                           input logic m, input logic [2:0] op);
        bus.req_a[i*6 +: 6]      = a;
        bus.req_b[i*6 +: 6]      = b;
        bus.req_modo[i]          = m;
        bus.req_op_sel[i*3 +: 3] = op;
    endtask

    // Entered at posedge+1 with inputs driven; leaves at posedge+1 after the handshake edge.
    task automatic wait_grant(input logic [NREQ-1:0] exp_gnt, input bit push,
                              input exp_t e, output int n);
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 12) begin
            tick();
            #1;
            n++;
        end
        check("grant", int'(bus.req_ready), int'(exp_gnt));
        if (bus.req_ready != '0) begin
            if (push) sb.push_back(e);
            $display("grant req_ready=%b after %0d wait cycles", bus.req_ready, n);
            tick();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d o=%b, expected no response",
                             bus.rsp_id, bus.rsp_o);
                end else begin
                    e = sb.pop_front();
                    $display("rsp id=%0d o=%b carry=%b zero=%b (exp id=%0d o=%b carry=%b zero=%b)",
                             bus.rsp_id, bus.rsp_o, bus.rsp_carry, bus.rsp_zero,
                             e.id, e.o, e.c, e.z);
                    check("rsp_id",    int'(bus.rsp_id),    int'(e.id));
                    check("rsp_o",     int'(bus.rsp_o),     int'(e.o));
                    check("rsp_carry", int'(bus.rsp_carry), int'(e.c));
                    check("rsp_zero",  int'(bus.rsp_zero),  int'(e.z));
                end
            end
        end
    end

    initial begin : stim
        int n;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_modo   = '0;
        bus.req_op_sel = '0;
        bus.rsp_ready  = 1'b1;
        reset          = 1'b1;

        // Reset held two cycles with both requesters asking
        set_req(0, 6'h00, 6'h3F, 1'b1, OP_AND);
        set_req(1, 6'h00, 6'h3F, 1'b1, OP_OR);
        bus.req_valid = 2'b11;
        repeat (2) begin
            @(posedge clk);
            #2;
            check("rst_req_ready", int'(bus.req_ready), 0);
            check("rst_rsp_valid", int'(bus.rsp_valid), 0);
            check("rst_rsp_id",    int'(bus.rsp_id),    0);
            check("rst_rsp_o",     int'(bus.rsp_o),     0);
            check("rst_rsp_carry", int'(bus.rsp_carry), 0);
            check("rst_rsp_zero",  int'(bus.rsp_zero),  0);
            check("rst_busy",      int'(bus.busy),      0);
        end
        reset = 1'b0;
        bus.req_valid = '0;
        tick();

        // Single request from requester 0: AND 000000 & 111111
        set_req(0, 6'h00, 6'h3F, 1'b1, OP_AND);
        bus.req_valid = 2'b01;
        wait_grant(2'b01, 1'b1, mk(0, 6'h00, 0, 1), n);
        check("single_grant_delay", n, 0);
        bus.req_valid = '0;
        #1;
        check("exec_rsp_valid", int'(bus.rsp_valid), 0);
        check("exec_busy",      int'(bus.busy),      1);
        tick();
        #1;
        check("resp_rsp_valid", int'(bus.rsp_valid), 1);
        tick();

        // Requester 1 arithmetic add 111111 + 000001 wraps with carry
        set_req(1, 6'h3F, 6'h01, 1'b0, 3'b000);
        bus.req_valid = 2'b10;
        wait_grant(2'b10, 1'b1, mk(1, 6'h00, 1, 1), n);
        bus.req_valid = '0;
        repeat (3) tick();

        // Both requesters held valid from a fresh pointer: grants 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 6'h00, 6'h3F, 1'b1, OP_AND);
        set_req(1, 6'h00, 6'h3F, 1'b1, OP_OR);
        bus.req_valid = 2'b11;
        wait_grant(2'b01, 1'b1, mk(0, 6'h00, 0, 1), n);
        wait_grant(2'b10, 1'b1, mk(1, 6'h3F, 0, 0), n);
        wait_grant(2'b01, 1'b1, mk(0, 6'h00, 0, 1), n);
        wait_grant(2'b10, 1'b1, mk(1, 6'h3F, 0, 0), n);
        bus.req_valid = '0;
        repeat (3) tick();

        // Backpressure: response held 5 cycles while requester 1 waits
        bus.req_valid = 2'b01;
        wait_grant(2'b01, 1'b1, mk(0, 6'h00, 0, 1), n);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b10;
        tick();
        repeat (5) begin
            #1;
            check("bp_rsp_valid", int'(bus.rsp_valid), 1);
            check("bp_rsp_o",     int'(bus.rsp_o),     0);
            check("bp_rsp_zero",  int'(bus.rsp_zero),  1);
            check("bp_rsp_id",    int'(bus.rsp_id),    0);
            check("bp_req_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", int'(bus.req_ready), 0);
        tick();
        wait_grant(2'b10, 1'b1, mk(1, 6'h3F, 0, 0), n);
        check("bp_grant_delay", n, 0);
        bus.req_valid = '0;
        repeat (3) tick();

        // Reset during EXEC of a requester-1 XOR: operation dropped
        set_req(1, 6'h2A, 6'h15, 1'b1, OP_XOR);
        bus.req_valid = 2'b10;
        wait_grant(2'b10, 1'b0, mk(1, 6'h3F, 0, 0), n);
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", int'(bus.req_ready), 0);
        tick();
        #1;
        check("post_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("post_rst_busy",      int'(bus.busy),      0);
        reset = 1'b0;
        set_req(0, 6'h00, 6'h3F, 1'b1, OP_AND);
        bus.req_valid = 2'b11;
        wait_grant(2'b01, 1'b1, mk(0, 6'h00, 0, 1), n);
        wait_grant(2'b10, 1'b1, mk(1, 6'h3F, 0, 0), n);
        bus.req_valid = '0;

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
